// File: rtl/serial_subtractor4_if.sv
// Handshake and data bundle for the bit-serial subtractor.
// master drives requests/operands/ack; slave returns status and result.
interface serial_subtractor4_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ack;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             zero;

    modport master (
        output start, a, b, bin, ack,
        input  ready, done, d, bout, zero
    );

    modport slave (
        input  start, a, b, bin, ack,
        output ready, done, d, bout, zero
    );
endinterface

// File: rtl/serial_subtractor4.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first.
// A single full-subtractor cell feeds a borrow flop; the result is shifted
// in from the MSB side and published to d/bout/zero only when complete,
// so the outputs stay stable across IDLE and the next RUN.
module serial_subtractor4 #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor4_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             zero_q;

    logic             bit_a;
    logic             bit_b;
    logic             diff;
    logic             borrow_next;
    logic [WIDTH-1:0] r_next;
    logic             last;
    logic             accept;

    // Full-subtractor cell on the current LSBs plus the carried borrow.
    always_comb begin
        bit_a       = a_sh[0];
        bit_b       = b_sh[0];
        diff        = bit_a ^ bit_b ^ borrow;
        borrow_next = (~bit_a & bit_b) | (~bit_a & borrow) | (bit_b & borrow);
        r_next      = {diff, r_sh[WIDTH-1:1]};
        last        = (cnt == CW'(WIDTH - 1));
        // New request is taken in IDLE, or in DONE when the result is acked
        // in the same cycle (back-to-back, Ready never asserts).
        accept      = bus.start && ((state == IDLE) || ((state == DONE) && bus.ack));
    end

    // Control FSM plus datapath shift registers and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            d_q    <= '0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
        end else if (accept) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            borrow <= bus.bin;
            cnt    <= '0;
            state  <= RUN;
        end else begin
            case (state)
                IDLE: ;
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    r_sh   <= r_next;
                    borrow <= borrow_next;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        d_q    <= r_next;
                        bout_q <= borrow_next;
                        zero_q <= (r_next == '0);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready = (state == IDLE);
    assign bus.done  = (state == DONE);
    assign bus.d     = d_q;
    assign bus.bout  = bout_q;
    assign bus.zero  = zero_q;
endmodule

// File: tb/tb_serial_subtractor4.sv
// Scoreboard bench for serial_subtractor4: the driver pushes the expected
// result on each accepted Start, the monitor pops and compares on every
// rising Done.
module tb_serial_subtractor4;
    localparam int W = 4;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         zero;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];
    logic done_q;

    serial_subtractor4_if #(.WIDTH(W)) bus ();

    serial_subtractor4 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W:0] r;
        exp_t e;
        r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        e.d = r[W-1:0];
        e.bout = r[W];
        e.zero = (r[W-1:0] == '0);
        return e;
    endfunction

    // Monitor: compare on each entry into DONE; Ready/Done exclusivity every cycle.
    initial begin
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.ready && bus.done) chk("ready_done_exclusive", 1, 0);
            if (bus.done && !done_q) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("d", 32'(bus.d), 32'(e.d));
                    chk("bout", 32'(bus.bout), 32'(e.bout));
                    chk("zero", 32'(bus.zero), 32'(e.zero));
                end
            end
            done_q = bus.done;
        end
    end

    // Wait for Ready, pulse Start over one edge, record the expected result.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input logic [W-1:0] ed, input logic eb, input logic ez);
        exp_t e;
        for (int i = 0; i < 50 && !bus.ready; i++) @(negedge clk);
        if (!bus.ready) chk("ready_timeout", 0, 1);
        bus.a = a; bus.b = b; bus.bin = bin; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        e.d = ed; e.bout = eb; e.zero = ez;
        sb.push_back(e);
    endtask

    // Count edges from the accepting edge until Done is seen; bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.done) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic do_ack(input int delay);
        repeat (delay) @(negedge clk);
        bus.ack = 1'b1;
        @(posedge clk);
        #1 bus.ack = 1'b0;
    endtask

    initial begin
        int   lat;
        exp_t e;
        logic [W-1:0] ra, rb;
        logic rbin;
        checks = 0; errors = 0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.ack = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 1);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_d", 32'(bus.d), 0);
        chk("rst_bout", 32'(bus.bout), 0);
        chk("rst_zero", 32'(bus.zero), 0);
        rst = 1'b0;

        // Basic op and latency
        issue(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b0);
        wait_done(lat);
        chk("latency", 32'(lat), W);
        do_ack(0);

        // Directed vectors
        issue(4'd3, 4'd9, 1'b0, 4'd10, 1'b1, 1'b0); wait_done(lat); do_ack(1);
        issue(4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0); wait_done(lat); do_ack(0);
        issue(4'd7, 4'd7, 1'b0, 4'd0, 1'b0, 1'b1);  wait_done(lat); do_ack(2);

        // Hold in DONE with Ack low, operands wiggling during RUN and DONE
        issue(4'd5, 4'd2, 1'b0, 4'd3, 1'b0, 1'b0);
        bus.a = 4'd15; bus.b = 4'd14; bus.bin = 1'b1;
        wait_done(lat);
        for (int i = 0; i < 10; i++) begin
            bus.a = W'(i); bus.b = W'(15 - i);
            @(negedge clk);
            chk("hold_done", 32'(bus.done), 1);
            chk("hold_d", 32'(bus.d), 3);
        end
        do_ack(0);

        // Start during RUN ignored; then back-to-back Ack+Start
        issue(4'd12, 4'd4, 1'b1, 4'd7, 1'b0, 1'b0);
        @(negedge clk);
        bus.a = 4'd1; bus.b = 4'd1; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat);
        bus.a = 4'd15; bus.b = 4'd1; bus.bin = 1'b0; bus.ack = 1'b1; bus.start = 1'b1;
        @(posedge clk);
        #1 begin bus.ack = 1'b0; bus.start = 1'b0; end
        e.d = 4'd14; e.bout = 1'b0; e.zero = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        chk("b2b_ready", 32'(bus.ready), 0);
        chk("b2b_done", 32'(bus.done), 0);
        wait_done(lat);
        chk("b2b_latency", 32'(lat), W);
        do_ack(0);

        // Async reset two cycles into RUN
        issue(4'd6, 4'd1, 1'b0, 4'd5, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_ready", 32'(bus.ready), 1);
        chk("arst_done", 32'(bus.done), 0);
        chk("arst_d", 32'(bus.d), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        issue(4'd8, 4'd5, 1'b0, 4'd3, 1'b0, 1'b0); wait_done(lat); do_ack(0);

        // Random regression against the reference model
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            rbin = 1'($urandom_range(0, 1));
            e = model(ra, rb, rbin);
            issue(ra, rb, rbin, e.d, e.bout, e.zero);
            wait_done(lat);
            do_ack(int'($urandom_range(0, 3)));
        end

        @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/serial_subtractor4.md
Name: serial_subtractor4

Overview:
- Bit-serial subtractor: D = A - B - Bin over WIDTH operand bits.
- Processes one bit per clock, LSB first, using a single full-subtractor cell and a borrow flop.
- Uses a Start / Done / Ack handshake.
- It is the inverse-operation companion to the team's combinational ripple adder. It is used where the area of a full parallel subtractor is not justified and multi-cycle latency is acceptable.

Parameters:
- WIDTH, 4, operand and result width in bits (>= 2).

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  request; sampled only in IDLE, or in DONE together with Ack
- A  input  WIDTH  minuend; captured on accepted Start
- B  input  WIDTH  subtrahend; captured on accepted Start
- Bin  input  1  borrow-in; captured on accepted Start
- Ack  input  1  consumer acknowledge of the result; sampled only in DONE
- Ready  output  1  high in IDLE
- Done  output  1  high in DONE
- D  output  WIDTH  difference, registered
- Bout  output  1  borrow-out, registered
- Zero  output  1  high when D == 0, registered with D

Behaviour:
- States: IDLE, RUN, DONE, encoded in 2 bits. Any illegal encoding returns to IDLE on the next edge.
- Reset (async, Reset=1):
  - state = IDLE.
  - Operand shift registers, result shift register, bit counter and borrow flop = 0.
  - D = 0, Bout = 0, Zero = 0, Done = 0, Ready = 1.
  - Reset asserted mid-RUN discards the operation; no Done is produced.
- IDLE:
  - Start=1 at a rising edge: capture A, B into shift regs, load borrow flop with Bin, counter = 0, go to RUN.
  - Start=0: stay in IDLE.
- RUN:
  - Each edge: a = A_sh[0], b = B_sh[0], c = borrow.
  - diff = a ^ b ^ c.
  - borrow_next = (~a & b) | (~a & c) | (b & c).
  - Shift diff into the MSB of the result shift reg (right shift). Shift A_sh and B_sh right. Counter increments.
  - On the edge where counter == WIDTH-1: go to DONE.
    - D = completed result including that edge's diff bit.
    - Bout = borrow_next.
    - Zero = (completed result == 0).
  - Start is ignored in RUN.
  - Inputs A, B, Bin may change freely during RUN with no effect.
- Latency: Start accepted at edge k, then Done=1 after edge k+WIDTH. For WIDTH=4, that is 4 clocks after the accepting edge.
- DONE:
  - Done=1. D, Bout and Zero are held stable.
  - Ack=0: stay in DONE indefinitely.
  - Ack=1, Start=0: go to IDLE; D/Bout/Zero are still held.
  - Ack=1, Start=1: back-to-back; capture new operands and go directly to RUN. Ready never asserts.
- D/Bout/Zero update only on the RUN to DONE edge; they hold through IDLE and the following RUN.
- Arithmetic: result is modulo 2^WIDTH. Bout=1 iff A < B + Bin (unsigned). This equals {Bout,D} = {1'b0,A} - {1'b0,B} - Bin in 2's complement.
- Ready and Done are decoded from state; they are never both 1.

Test Plan:
- Reset, then A=9, B=3, Bin=0, Start pulse in IDLE -> Done rises 4 clocks after the accepting edge; D=6, Bout=0, Zero=0.
- A=3, B=9, Bin=0 -> D=4'b1010 (10), Bout=1. Then A=0, B=0, Bin=1 -> D=15, Bout=1. Then A=7, B=7, Bin=0 -> D=0, Zero=1, Bout=0.
- Hold Ack=0 for 10 cycles in DONE -> Done stays 1 and D stable; changing A/B during RUN and DONE does not alter D.
- Start re-pulsed during RUN -> ignored. Ack and Start together in DONE with A=15, B=1 -> no IDLE cycle; next Done gives D=14, Bout=0.
- Assert Reset asynchronously (mid-cycle) 2 cycles into RUN -> immediately Ready=1, Done=0, D=0. A new Start afterwards completes correctly.
- Randomised regression: 1000 random A, B, Bin with random Ack delays -> every {Bout,D} matches the reference model {1'b0,A}-{1'b0,B}-Bin.
